// File: rtl/music_defs.sv
// Shared widths, sample rate and FSM state encodings for the note playback path.
package music_defs;

    localparam int NOTE_W      = 6;
    localparam int DUR_W       = 6;
    localparam int PHASE_W     = 22;
    localparam int STEP_W      = 20;
    localparam int SAMPLE_RATE = 48000;

    typedef enum logic [1:0] {
        NP_IDLE    = 2'd0,
        NP_PLAYING = 2'd1,
        NP_DONE    = 2'd2
    } np_state_t;

endpackage

// File: rtl/note_step_rom.sv
// Combinational phase-increment table: step = round(f_note * 2^PHASE_W / SAMPLE_RATE).
module note_step_rom
    import music_defs::*;
(
    input  logic [NOTE_W-1:0] note,
    output logic [STEP_W-1:0] step
);

    // Note 49 is A4 (440 Hz); one entry per equal-tempered semitone, note 0 is a rest.
    always_comb begin
        step = '0;
        case (note)
            6'd0:  step = STEP_W'(0);
            6'd1:  step = STEP_W'(2403);
            6'd2:  step = STEP_W'(2546);
            6'd3:  step = STEP_W'(2697);
            6'd4:  step = STEP_W'(2858);
            6'd5:  step = STEP_W'(3028);
            6'd6:  step = STEP_W'(3208);
            6'd7:  step = STEP_W'(3398);
            6'd8:  step = STEP_W'(3600);
            6'd9:  step = STEP_W'(3815);
            6'd10: step = STEP_W'(4041);
            6'd11: step = STEP_W'(4282);
            6'd12: step = STEP_W'(4536);
            6'd13: step = STEP_W'(4806);
            6'd14: step = STEP_W'(5092);
            6'd15: step = STEP_W'(5395);
            6'd16: step = STEP_W'(5715);
            6'd17: step = STEP_W'(6055);
            6'd18: step = STEP_W'(6415);
            6'd19: step = STEP_W'(6797);
            6'd20: step = STEP_W'(7201);
            6'd21: step = STEP_W'(7629);
            6'd22: step = STEP_W'(8083);
            6'd23: step = STEP_W'(8563);
            6'd24: step = STEP_W'(9072);
            6'd25: step = STEP_W'(9612);
            6'd26: step = STEP_W'(10184);
            6'd27: step = STEP_W'(10789);
            6'd28: step = STEP_W'(11431);
            6'd29: step = STEP_W'(12110);
            6'd30: step = STEP_W'(12830);
            6'd31: step = STEP_W'(13593);
            6'd32: step = STEP_W'(14402);
            6'd33: step = STEP_W'(15258);
            6'd34: step = STEP_W'(16165);
            6'd35: step = STEP_W'(17127);
            6'd36: step = STEP_W'(18145);
            6'd37: step = STEP_W'(19224);
            6'd38: step = STEP_W'(20367);
            6'd39: step = STEP_W'(21578);
            6'd40: step = STEP_W'(22861);
            6'd41: step = STEP_W'(24221);
            6'd42: step = STEP_W'(25661);
            6'd43: step = STEP_W'(27187);
            6'd44: step = STEP_W'(28803);
            6'd45: step = STEP_W'(30516);
            6'd46: step = STEP_W'(32331);
            6'd47: step = STEP_W'(34253);
            6'd48: step = STEP_W'(36290);
            6'd49: step = STEP_W'(38448);
            6'd50: step = STEP_W'(40734);
            6'd51: step = STEP_W'(43156);
            6'd52: step = STEP_W'(45722);
            6'd53: step = STEP_W'(48441);
            6'd54: step = STEP_W'(51322);
            6'd55: step = STEP_W'(54373);
            6'd56: step = STEP_W'(57607);
            6'd57: step = STEP_W'(61032);
            6'd58: step = STEP_W'(64661);
            6'd59: step = STEP_W'(68506);
            6'd60: step = STEP_W'(72580);
            6'd61: step = STEP_W'(76896);
            6'd62: step = STEP_W'(81468);
            6'd63: step = STEP_W'(86312);
            default: step = '0;
        endcase
    end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: counts its duration in beats and advances a phase
// accumulator at the sample rate for the sample ROM stage downstream.
module note_player
    import music_defs::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               beat,
    input  logic               generate_next_sample,
    input  logic               new_note,
    input  logic [NOTE_W-1:0]  note,
    input  logic [DUR_W-1:0]   duration,
    output logic               note_done,
    output logic               active,
    output logic [PHASE_W-1:0] phase,
    output logic [STEP_W-1:0]  step_size
);

    np_state_t          state_reg, state_next;
    logic [NOTE_W-1:0]  cur_note_reg, cur_note_next;
    logic [DUR_W-1:0]   remaining_reg, remaining_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;

    note_step_rom u_step_rom (
        .note (cur_note_reg),
        .step (step_size)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= NP_IDLE;
            cur_note_reg  <= '0;
            remaining_reg <= '0;
            phase_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cur_note_reg  <= cur_note_next;
            remaining_reg <= remaining_next;
            phase_reg     <= phase_next;
        end
    end

    // A new note always wins, in every state and over a coincident beat.
    always_comb begin
        state_next     = state_reg;
        cur_note_next  = cur_note_reg;
        remaining_next = remaining_reg;
        phase_next     = phase_reg;

        if (new_note) begin
            cur_note_next  = note;
            remaining_next = duration;
            phase_next     = '0;
            state_next     = (duration != '0) ? NP_PLAYING : NP_DONE;
        end else begin
            case (state_reg)
                NP_PLAYING: begin
                    if (play) begin
                        if (beat) begin
                            remaining_next = remaining_reg - DUR_W'(1);
                            if (remaining_reg == DUR_W'(1)) begin
                                state_next = NP_DONE;
                            end
                        end
                        if (generate_next_sample) begin
                            phase_next = phase_reg + PHASE_W'(step_size);
                        end
                    end
                end
                NP_DONE: begin
                    state_next = NP_IDLE;
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    assign note_done = (state_reg == NP_DONE);
    assign active    = (state_reg == NP_PLAYING) && (cur_note_reg != '0) && play;
    assign phase     = phase_reg;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: a directed vector table, directed corner sequences and
// random traffic, all compared against a cycle-level behavioural model.
module tb_note_player;
    import music_defs::*;

    localparam longint PHASE_MOD = 64'd1 << PHASE_W;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               play = 1'b0;
    logic               beat = 1'b0;
    logic               generate_next_sample = 1'b0;
    logic               new_note = 1'b0;
    logic [NOTE_W-1:0]  note = '0;
    logic [DUR_W-1:0]   duration = '0;
    logic               note_done;
    logic               active;
    logic [PHASE_W-1:0] phase;
    logic [STEP_W-1:0]  step_size;

    note_player dut (
        .clk                  (clk),
        .reset                (reset),
        .play                 (play),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .new_note             (new_note),
        .note                 (note),
        .duration             (duration),
        .note_done            (note_done),
        .active               (active),
        .phase                (phase),
        .step_size            (step_size)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: what is sounding, how many beats are left, where the phase is.
    int     m_note = 0;
    int     m_left = 0;
    longint m_phase = 0;
    bit     m_busy = 1'b0;
    bit     m_done = 1'b0;

    typedef struct {
        bit r, p, b, g, nn;
        int n, d;
        bit e_done, e_active;
        int e_phase, e_step;
    } vec_t;

    vec_t vecs[15];

    function automatic int ref_step(input int n);
        real f;
        if (n == 0) return 0;
        f = 440.0 * $pow(2.0, (n - 49) / 12.0) * real'(PHASE_MOD) / real'(SAMPLE_RATE);
        return $rtoi(f + 0.5);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input bit r, p, b, g, nn, input int n, d);
        if (r) begin
            m_busy = 0; m_done = 0; m_note = 0; m_left = 0; m_phase = 0;
        end else if (nn) begin
            m_note = n; m_left = d; m_phase = 0;
            m_busy = (d != 0);
            m_done = (d == 0);
        end else if (m_busy) begin
            m_done = 0;
            if (p && g) m_phase = (m_phase + ref_step(m_note)) % PHASE_MOD;
            if (p && b) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_done = 0;
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, compare just after it.
    task automatic drive(input bit r, p, b, g, nn, input int n, d);
        reset = r; play = p; beat = b; generate_next_sample = g; new_note = nn;
        note = NOTE_W'(n); duration = DUR_W'(d);
        @(posedge clk);
        model_step(r, p, b, g, nn, n, d);
        #1;
        check("model_note_done", note_done, m_done);
        check("model_active", active, m_busy && (m_note != 0) && p);
        check("model_phase", phase, m_phase);
        check("model_step_size", step_size, ref_step(m_note));
    endtask

    int done_count;

    initial begin
        //            r  p  b  g  nn  n   d   done act phase   step
        vecs[0]  = '{1, 0, 0, 0, 0,  0,  0,  0,   0,  0,      0};
        vecs[1]  = '{0, 1, 0, 0, 1,  49, 2,  0,   1,  0,      38448};
        vecs[2]  = '{0, 1, 0, 1, 0,  0,  0,  0,   1,  38448,  38448};
        vecs[3]  = '{0, 1, 1, 1, 0,  0,  0,  0,   1,  76896,  38448};
        vecs[4]  = '{0, 1, 0, 1, 0,  0,  0,  0,   1,  115344, 38448};
        vecs[5]  = '{0, 1, 0, 1, 0,  0,  0,  0,   1,  153792, 38448};
        vecs[6]  = '{0, 1, 1, 0, 0,  0,  0,  1,   0,  153792, 38448};
        vecs[7]  = '{0, 1, 0, 0, 0,  0,  0,  0,   0,  153792, 38448};
        vecs[8]  = '{0, 1, 0, 0, 1,  0,  0,  1,   0,  0,      0};
        vecs[9]  = '{0, 1, 0, 0, 0,  0,  0,  0,   0,  0,      0};
        vecs[10] = '{0, 1, 1, 0, 1,  63, 5,  0,   1,  0,      86312};
        vecs[11] = '{0, 0, 1, 1, 0,  0,  0,  0,   0,  0,      86312};
        vecs[12] = '{0, 1, 0, 1, 0,  0,  0,  0,   1,  86312,  86312};
        vecs[13] = '{0, 1, 0, 0, 1,  10, 1,  0,   1,  0,      4041};
        vecs[14] = '{0, 1, 1, 0, 0,  0,  0,  1,   0,  0,      4041};

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].r, vecs[i].p, vecs[i].b, vecs[i].g, vecs[i].nn, vecs[i].n, vecs[i].d);
            check($sformatf("vec%0d_note_done", i), note_done, vecs[i].e_done);
            check($sformatf("vec%0d_active", i), active, vecs[i].e_active);
            check($sformatf("vec%0d_phase", i), phase, vecs[i].e_phase);
            check($sformatf("vec%0d_step", i), step_size, vecs[i].e_step);
        end
        drive(0, 1, 0, 0, 0, 0, 0);

        // Full step table sweep.
        for (int n = 0; n < 64; n++) begin
            drive(0, 1, 0, 0, 1, n, 1);
            check($sformatf("rom_step_%0d", n), step_size, ref_step(n));
        end
        check("rom_step_49_const", ref_step(49), 38448);

        // Wrap: note 63 for 60 samples passes 2^PHASE_W once.
        drive(0, 1, 0, 0, 1, 63, 1);
        for (int i = 0; i < 60; i++) drive(0, 1, 0, 1, 0, 0, 0);
        check("wrap_phase", phase, (60 * 86312) % 4194304);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("wrap_done", note_done, 1);

        // Pause across 3 beats and 5 samples, then resume.
        done_count = 0;
        drive(0, 1, 0, 0, 1, 49, 2);
        drive(0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, (i % 3) == 0, (i % 3) != 0, 0, 0, 0);
            done_count += int'(note_done);
            check("pause_phase", phase, 38448);
            check("pause_active", active, 0);
        end
        drive(0, 1, 1, 0, 0, 0, 0);
        done_count += int'(note_done);
        check("resume_active", active, 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        done_count += int'(note_done);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("resume_done", note_done, 1);
        done_count += int'(note_done);
        drive(0, 1, 0, 0, 0, 0, 0);
        done_count += int'(note_done);
        check("pause_done_count", done_count, 1);

        // Rest note: silent, phase pinned at 0, still counts its beat.
        drive(0, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0, 0, 0);
            check("rest_phase", phase, 0);
            check("rest_active", active, 0);
        end
        drive(0, 1, 1, 0, 0, 0, 0);
        check("rest_done", note_done, 1);

        // Zero duration: done straight after the load, no beat needed.
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 20, 0);
        check("zero_dur_done", note_done, 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("zero_dur_done_clear", note_done, 0);

        // Restart while playing: old note never reports done.
        drive(0, 1, 0, 1, 1, 30, 2);
        drive(0, 1, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 40, 1);
        check("restart_done", note_done, 0);
        check("restart_phase", phase, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        check("restart_new_done", note_done, 1);

        // Reset mid-note.
        drive(0, 1, 0, 0, 1, 49, 3);
        drive(0, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 0);
        check("reset_note_done", note_done, 0);
        check("reset_active", active, 0);
        check("reset_phase", phase, 0);
        check("reset_step", step_size, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 0, 0, 0);
            check("post_reset_done", note_done, 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 85,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 5)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
